// File: rtl/mem_handshake_ram_if.sv
// Control-unit to RAM memory handshake: request (mfa/rw/mas/addr/din) and completion (mfc/dout).
// Valid/ready rule: the master raises mfa with stable request fields and holds it until mfc=1; it then drops mfa to release the slave.
interface mem_handshake_ram_if #(
    parameter int ADDR_W = 8
);
    logic              mfa;
    logic              rw;
    logic [1:0]        mas;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic              mfc;

    modport master (
        output mfa, rw, mas, addr, din,
        input  dout, mfc
    );

    modport slave (
        input  mfa, rw, mas, addr, din,
        output dout, mfc
    );
endinterface

// File: rtl/mem_handshake_ram.sv
// Byte-addressable big-endian RAM with programmable MFA-to-MFC latency.
// The three-state handshake FSM is exposed on dbg_state (0 IDLE, 1 BUSY, 2 DONE).
module mem_handshake_ram #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 CLR,
    mem_handshake_ram_if.slave   bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem [DEPTH];
    state_t            state;
    logic [3:0]        cnt;
    logic              req_rw;
    logic [1:0]        req_mas;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_din;

    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       rdata;
    logic              fire;
    logic              do_write;

    // Alignment drops the low bits, so a halfword/word never runs past the top byte.
    always_comb begin
        a0 = req_addr;
        case (req_mas)
            2'b00:   a0 = req_addr;
            2'b01:   a0[0] = 1'b0;
            default: a0[1:0] = 2'b00;
        endcase
        a1 = a0 + ADDR_W'(1);
        a2 = a0 + ADDR_W'(2);
        a3 = a0 + ADDR_W'(3);
    end

    always_comb begin
        rdata = 32'd0;
        case (req_mas)
            2'b00:   rdata = {24'd0, mem[a0]};
            2'b01:   rdata = {16'd0, mem[a0], mem[a1]};
            default: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    assign fire      = (state == BUSY) && (cnt == 4'd0);
    assign do_write  = fire && !req_rw;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            bus.mfc  <= 1'b0;
            bus.dout <= 32'd0;
            req_rw   <= 1'b1;
            req_mas  <= 2'b00;
            req_addr <= '0;
            req_din  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.mfc <= 1'b0;
                    if (bus.mfa) begin
                        req_rw   <= bus.rw;
                        req_mas  <= bus.mas;
                        req_addr <= bus.addr;
                        req_din  <= bus.din;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (req_rw) bus.dout <= rdata;
                        bus.mfc <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.mfa) begin
                        bus.mfc <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    bus.mfc <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // The array has no reset; an aborted request never reaches here because CLR forces IDLE.
    always_ff @(posedge clk) begin
        if (do_write) begin
            case (req_mas)
                2'b00: mem[a0] <= req_din[7:0];
                2'b01: begin
                    mem[a0] <= req_din[15:8];
                    mem[a1] <= req_din[7:0];
                end
                default: begin
                    mem[a0] <= req_din[31:24];
                    mem[a1] <= req_din[23:16];
                    mem[a2] <= req_din[15:8];
                    mem[a3] <= req_din[7:0];
                end
            endcase
        end
    end
endmodule
